// File: rtl/step_sequencer.sv
// Drum step sequencer: per-lane 8-step patterns, step timer and one-cycle trigger pulses.
// Optional swing timing on odd steps is enabled by defining SEQ_SWING_EN.
module step_sequencer #(
    parameter int NUM_INS    = 4,
    parameter int STEPS      = 8,
    parameter int PERIOD_W   = 28,
    parameter int MIN_PERIOD = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [PERIOD_W-1:0]        step_period,
    input  logic                       pat_wr_en,
    input  logic [1:0]                 pat_wr_sel,
    input  logic [STEPS-1:0]           pat_wr_data,
    output logic [NUM_INS-1:0]         trig,
    output logic [$clog2(STEPS)-1:0]   step,
    output logic                       playing,
    output logic                       bar_start,
    output logic                       pending
);

    localparam int SW = $clog2(STEPS);
    localparam int CW = PERIOD_W + 1;  // headroom for period + swing

    typedef enum logic {IDLE, PLAY} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      step_q, step_d, step_inc;
    logic [NUM_INS-1:0] trig_q, trig_d;
    logic               bar_q, bar_d;
    logic               pend_q, pend_d;
    logic [STEPS-1:0]   act_q [NUM_INS];
    logic [STEPS-1:0]   act_d [NUM_INS];
    logic [STEPS-1:0]   shd_q [NUM_INS];
    logic [STEPS-1:0]   shd_d [NUM_INS];
    logic [PERIOD_W-1:0] eff_q, eff_d, eff_new;
    logic [CW-1:0]      bar_reload, run_reload;

    assign eff_new  = (step_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : step_period;
    assign step_inc = step_q + 1'b1;

`ifdef SEQ_SWING_EN
    // step 0 is even, so a bar always opens with the lengthened interval
    assign bar_reload = CW'(eff_new) + CW'(eff_new >> 2) - CW'(1);
    assign run_reload = step_inc[0] ? CW'(eff_q) - CW'(eff_q >> 2) - CW'(1)
                                    : CW'(eff_q) + CW'(eff_q >> 2) - CW'(1);
`else
    assign bar_reload = CW'(eff_new) - CW'(1);
    assign run_reload = CW'(eff_q) - CW'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            trig_q  <= '0;
            bar_q   <= 1'b0;
            pend_q  <= 1'b0;
            eff_q   <= '0;
            for (int unsigned i = 0; i < NUM_INS; i++) begin
                act_q[i] <= '0;
                shd_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            trig_q  <= trig_d;
            bar_q   <= bar_d;
            pend_q  <= pend_d;
            eff_q   <= eff_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        trig_d  = '0;
        bar_d   = 1'b0;
        pend_d  = pend_q;
        eff_d   = eff_q;
        act_d   = act_q;
        shd_d   = shd_q;

        if (pat_wr_en)
            shd_d[pat_wr_sel] = pat_wr_data;

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = '0;
            act_d   = shd_d;
            pend_d  = 1'b0;
        end else if (start) begin
            state_d = PLAY;
            step_d  = '0;
            bar_d   = 1'b1;
            eff_d   = eff_new;
            cnt_d   = bar_reload;
            // In IDLE shadow == active, so shd_q is the committed set either way
            for (int unsigned i = 0; i < NUM_INS; i++)
                trig_d[i] = shd_q[i][0];
            if (state_q == IDLE) begin
                act_d  = shd_d;
                pend_d = 1'b0;
            end else begin
                act_d  = shd_q;
                pend_d = pat_wr_en;
            end
        end else if (state_q == IDLE) begin
            act_d = shd_d;
        end else begin
            if (pat_wr_en)
                pend_d = 1'b1;
            if (cnt_q == '0) begin
                step_d = step_inc;
                if (step_inc == '0) begin
                    // commit uses the pre-write shadow; a same-cycle write waits a bar
                    bar_d  = 1'b1;
                    eff_d  = eff_new;
                    cnt_d  = bar_reload;
                    act_d  = shd_q;
                    pend_d = pat_wr_en;
                    for (int unsigned i = 0; i < NUM_INS; i++)
                        trig_d[i] = shd_q[i][0];
                end else begin
                    cnt_d = run_reload;
                    for (int unsigned i = 0; i < NUM_INS; i++)
                        trig_d[i] = act_q[i][step_inc];
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    assign trig      = trig_q;
    assign step      = step_q;
    assign playing   = (state_q == PLAY);
    assign bar_start = bar_q;
    assign pending   = pend_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: trigger timing, double-buffered pattern commit,
// period clamp, stop/reset priority; gap expectations follow SEQ_SWING_EN.
module tb_step_sequencer;

`ifdef SEQ_SWING_EN
    localparam int EVEN_GAP = 125, ODD_GAP = 75, MIN_EVEN = 20, MIN_ODD = 12;
`else
    localparam int EVEN_GAP = 100, ODD_GAP = 100, MIN_EVEN = 16, MIN_ODD = 16;
`endif
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [27:0] step_period = 28'd100;
    logic        pat_wr_en = 1'b0;
    logic [1:0]  pat_wr_sel = 2'd0;
    logic [7:0]  pat_wr_data = 8'h00;
    logic [3:0]  trig;
    logic [2:0]  step;
    logic        playing;
    logic        bar_start;
    logic        pending;

    int n_checks = 0;
    int n_pass   = 0;

    step_sequencer #(
        .NUM_INS(4), .STEPS(8), .PERIOD_W(28), .MIN_PERIOD(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .step_period(step_period), .pat_wr_en(pat_wr_en),
        .pat_wr_sel(pat_wr_sel), .pat_wr_data(pat_wr_data),
        .trig(trig), .step(step), .playing(playing),
        .bar_start(bar_start), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        pat_wr_en = 1'b1; pat_wr_sel = sel; pat_wr_data = data;
        tick();
        pat_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic wait_trig(output int n);
        tick(); n = 1;
        while (trig == 4'd0 && n < LIMIT) begin tick(); n++; end
        if (trig == 4'd0) check("wait_trig_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_step(input logic [2:0] target);
        int n = 0;
        while (step != target && n < LIMIT) begin tick(); n++; end
        if (step != target) check("wait_step_timeout", 32'(step), 32'(target));
    endtask

    task automatic wait_bar(output logic [3:0] acc);
        int n = 0;
        acc = 4'd0;
        tick();
        while (!bar_start && n < LIMIT) begin acc |= trig; tick(); n++; end
        if (!bar_start) check("wait_bar_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, total;
        logic [3:0] acc;

        // reset state
        tick(); tick();
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        check("rst_bar", 32'(bar_start), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        reset = 1'b0;
        tick();

        // basic timing, lane0 = steps 0 and 2
        step_period = 28'd100;
        wr(2'd0, 8'b0000_0101);
        check("idle_wr_pending", 32'(pending), 32'd0);
        pulse_start();
        check("start_trig", 32'(trig), 32'd1);
        check("start_bar", 32'(bar_start), 32'd1);
        check("start_step", 32'(step), 32'd0);
        check("start_playing", 32'(playing), 32'd1);
        wait_trig(n);
        check("gap_s0_s2", 32'(n), 32'd200);
        check("s2_trig", 32'(trig), 32'd1);
        check("s2_step", 32'(step), 32'd2);
        wait_trig(n);
        check("gap_s2_s0", 32'(n), 32'd600);
        check("bar2_bar", 32'(bar_start), 32'd1);
        check("bar2_step", 32'(step), 32'd0);

        // shadow write mid-bar, committed at wrap
        pulse_stop();
        check("stop_playing", 32'(playing), 32'd0);
        check("stop_step", 32'(step), 32'd0);
        check("stop_trig", 32'(trig), 32'd0);
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h01);
        pulse_start();
        check("l1_start_trig", 32'(trig), 32'b0010);
        wait_step(3'd3);
        wr(2'd1, 8'hFF);
        check("mid_pending", 32'(pending), 32'd1);
        wait_bar(acc);
        check("no_trig_s4_7", 32'(acc), 32'd0);
        check("commit_trig", 32'(trig), 32'b0010);
        check("commit_pending", 32'(pending), 32'd0);
        wait_trig(n);
        check("commit_gap", 32'(n), 32'(EVEN_GAP));
        check("commit_s1_trig", 32'(trig), 32'b0010);
        check("commit_s1_step", 32'(step), 32'd1);

        // write landing exactly on the wrap edge
        wait_step(3'd7);
        repeat (ODD_GAP - 1) tick();
        wr(2'd2, 8'h01);
        check("wrapwr_bar", 32'(bar_start), 32'd1);
        check("wrapwr_trig", 32'(trig), 32'b0010);
        check("wrapwr_pending", 32'(pending), 32'd1);
        wait_bar(acc);
        check("nextbar_trig", 32'(trig), 32'b0110);
        check("nextbar_pending", 32'(pending), 32'd0);

        // period clamp
        pulse_stop();
        step_period = 28'd3;
        pulse_start();
        check("clamp_start_trig", 32'(trig), 32'b0110);
        wait_trig(n);
        check("clamp_gap0", 32'(n), 32'(MIN_EVEN));
        check("clamp_s1_trig", 32'(trig), 32'b0010);
        wait_trig(n);
        check("clamp_gap1", 32'(n), 32'(MIN_ODD));
        check("clamp_s2_step", 32'(step), 32'd2);

        // all lanes, full bar of gaps
        pulse_stop();
        for (int i = 0; i < 4; i++) wr(2'(i), 8'hFF);
        step_period = 28'd100;
        pulse_start();
        check("all_start_trig", 32'(trig), 32'hF);
        total = 0;
        for (int k = 0; k < 8; k++) begin
            wait_trig(n);
            check($sformatf("gap_%0d", k), 32'(n), 32'((k % 2 == 0) ? EVEN_GAP : ODD_GAP));
            total += n;
        end
        check("bar_len", 32'(total), 32'd800);
        check("bar_len_bar", 32'(bar_start), 32'd1);

        // start+stop together on a step-fire edge
        repeat (EVEN_GAP - 1) tick();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_trig", 32'(trig), 32'd0);
        check("ss_playing", 32'(playing), 32'd0);
        check("ss_step", 32'(step), 32'd0);
        check("ss_bar", 32'(bar_start), 32'd0);

        // asynchronous reset mid-step
        pulse_start();
        repeat (30) tick();
        #2 reset = 1'b1;
        #1;
        check("areset_trig", 32'(trig), 32'd0);
        check("areset_step", 32'(step), 32'd0);
        check("areset_playing", 32'(playing), 32'd0);
        check("areset_bar", 32'(bar_start), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        acc = 4'd0;
        for (int c = 0; c < 200; c++) begin tick(); acc |= trig; end
        check("post_reset_trig", 32'(acc), 32'd0);
        check("post_reset_playing", 32'(playing), 32'd0);
        pulse_start();
        check("cleared_pat_trig", 32'(trig), 32'd0);
        check("cleared_pat_bar", 32'(bar_start), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
